// File: rtl/imex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imex_pkg
//  Description : Shared byte width, bytes-per-pixel helper and FSM state
//                encoding for the pixel serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package imex_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int nb_of(input int dw);
        return dw / BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imex_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : imex_sync_fifo
//  Description : Single-clock FIFO with wrap-bit pointers; exposes the head
//                and the entry behind it so the reader can chain without gaps.
//  Revision    : 1.0 - initial release
// ============================================================================
module imex_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_multi,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_head_next
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic [AW-1:0]    w_rd_next_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty       = (r_wr_ptr == r_rd_ptr);
    assign o_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign o_multi       = (w_count > (AW+1)'(1));
    assign w_rd_next_idx = r_rd_ptr[AW-1:0] + AW'(1);
    assign o_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign o_head_next   = r_mem[w_rd_next_idx];

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/imex_px_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : imex_px_serializer
//  Description : Buffers incoming pixels and emits each one MSB-byte first
//                on a valid/ready byte stream; flags overflow stickily.
//  Revision    : 1.0 - initial release
// ============================================================================
module imex_px_serializer
    import imex_pkg::*;
#(
    parameter int DW    = 24,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [7:0]    o_data,
    output logic          o_last,
    output logic          o_error
);

    localparam int NB = nb_of(DW);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_shift;
    logic [CW-1:0] r_cnt;
    logic          r_error;
    logic          w_full;
    logic          w_empty;
    logic          w_multi;
    logic [DW-1:0] w_head;
    logic [DW-1:0] w_head_next;
    logic          w_last_xfer;

    assign w_last_xfer = o_valid & o_ready & o_last;

    imex_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (i_valid),
        .i_pop       (w_last_xfer),
        .i_data      (i_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_multi     (w_multi),
        .o_head      (w_head),
        .o_head_next (w_head_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty) w_state_nxt = ST_SEND;
            ST_SEND: if (w_last_xfer && !w_multi) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_valid = (r_state == ST_SEND);
        o_last  = o_valid && (r_cnt == CW'(NB - 1));
        o_data  = r_shift[DW-1 -: BYTE_W];
        o_error = r_error;
    end

    // The head stays queued while it is serialised; the entry behind it is
    // preloaded on the last byte so back-to-back pixels leave no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (!w_empty) begin
                r_shift <= w_head;
                r_cnt   <= '0;
            end
        end else if (o_valid && o_ready) begin
            if (o_last) begin
                r_shift <= w_multi ? w_head_next : (r_shift << BYTE_W);
                r_cnt   <= '0;
            end else begin
                r_shift <= r_shift << BYTE_W;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                r_error <= 1'b0;
        else if (i_valid && w_full && !w_last_xfer) r_error <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_imex_px_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imex_px_serializer
//  Description : Directed self-checking bench for imex_px_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imex_px_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [23:0] i_data;
    logic        o_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_last;
    logic        o_error;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q [$];

    imex_px_serializer #(.DW(24), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_error (o_error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted byte is compared with the next expected one.
    always @(negedge clk) begin
        if (rst && o_valid && o_ready) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL extra_byte obs=%02h exp=none", o_data);
            end
            if (exp_q.size() > 0) begin
                logic [8:0] e;
                e = exp_q.pop_front();
                total++;
                assert (o_data === e[7:0]) else begin
                    bad++;
                    $error("FAIL byte_data obs=%02h exp=%02h", o_data, e[7:0]);
                end
                total++;
                assert (o_last === e[8]) else begin
                    bad++;
                    $error("FAIL byte_last obs=%0b exp=%0b (data %02h)", o_last, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_px(input logic [23:0] px);
        for (int b = 0; b < 3; b++) begin
            logic [7:0] byt;
            byt = px[23 - 8*b -: 8];
            exp_q.push_back({(b == 2), byt});
        end
    endtask

    task automatic push_px(input logic [23:0] px, input bit accepted);
        i_valid = 1'b1;
        i_data  = px;
        if (accepted) expect_px(px);
        step();
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 200) begin
            step();
            n++;
        end
        chk(tag, {31'd0, (exp_q.size() == 0 && !o_valid)}, 32'd1);
    endtask

    initial begin
        rst     = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b1;
        step();
        step();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_last",  {31'd0, o_last},  32'd0);
        chk("rst_data",  {24'd0, o_data},  32'd0);
        chk("rst_error", {31'd0, o_error}, 32'd0);
        rst = 1'b1;
        step();

        // Single pixel: first byte two cycles after the strobe.
        push_px(24'hA1B2C3, 1'b1);
        chk("lat_cyc1_valid", {31'd0, o_valid}, 32'd0);
        step();
        chk("lat_cyc2_valid", {31'd0, o_valid}, 32'd1);
        chk("lat_cyc2_data",  {24'd0, o_data},  32'hA1);
        drain("drain_single");

        // Two back-to-back pixels: six contiguous bytes.
        push_px(24'h112233, 1'b1);
        push_px(24'h445566, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b_valid_%0d", k), {31'd0, o_valid}, 32'd1);
            step();
        end
        drain("drain_b2b");

        // Backpressure while B2 is presented.
        push_px(24'hA1B2C3, 1'b1);
        step();
        step();
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_data",  {24'd0, o_data},  32'hB2);
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_last",  {31'd0, o_last},  32'd0);
            step();
        end
        o_ready = 1'b1;
        drain("drain_stall");

        // Overflow: fifth push into a full FIFO is dropped.
        o_ready = 1'b0;
        push_px(24'h010101, 1'b1);
        push_px(24'h020202, 1'b1);
        push_px(24'h030303, 1'b1);
        push_px(24'h040404, 1'b1);
        chk("ovf_err_before", {31'd0, o_error}, 32'd0);
        push_px(24'h050505, 1'b0);
        chk("ovf_err_after", {31'd0, o_error}, 32'd1);
        o_ready = 1'b1;
        drain("drain_ovf");
        chk("ovf_err_sticky", {31'd0, o_error}, 32'd1);

        // Full FIFO push coinciding with the head's last byte is accepted.
        rst = 1'b0;
        step();
        chk("rst2_error", {31'd0, o_error}, 32'd0);
        rst = 1'b1;
        o_ready = 1'b0;
        push_px(24'h101112, 1'b1);
        push_px(24'h202122, 1'b1);
        push_px(24'h303132, 1'b1);
        push_px(24'h404142, 1'b1);
        o_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!o_last && n < 20) begin
                step();
                n++;
            end
            chk("coin_found_last", {31'd0, o_last}, 32'd1);
        end
        push_px(24'h606162, 1'b1);
        chk("coin_err", {31'd0, o_error}, 32'd0);
        drain("drain_coin");
        chk("coin_err_end", {31'd0, o_error}, 32'd0);

        // Reset mid-pixel discards the remainder.
        push_px(24'hDEADBE, 1'b1);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_data",  {24'd0, o_data},  32'd0);
        chk("midrst_last",  {31'd0, o_last},  32'd0);
        exp_q.delete();
        step();
        rst = 1'b1;
        step();
        chk("post_rst_idle", {31'd0, o_valid}, 32'd0);
        push_px(24'h010203, 1'b1);
        drain("drain_post_rst");
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
